fifo_rd_arbiter: RTL and testbench

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_rd_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_rd_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_rd_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO read arbiter.
// State encoding plus parameter defaults used by the top and picker.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_MAX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_picker.sv
// Round-robin winner search for the FIFO read arbiter.
// Scans upward from rr_ptr with wrap; first set request wins.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  logic [PTR_W-1:0] k;

  // First requester at or above the pointer, wrapping past the top.
  always_comb begin
    winner = '0;
    k      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (winner == '0 && req[k]) begin
        winner[k] = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Arbitrates one FIFO read port among several consumers in bursts.
// Grant lifecycle: IDLE select -> BURST beats -> one DRAIN cycle.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    cons_rdy,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic                  burst_done
);

  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   out_valid_q;
  logic                 burst_done_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [PTR_W-1:0]     ptr_d;
  logic [PTR_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_win;
  logic                 pick_any;
  logic                 req_g;
  logic                 burst_end;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_win),
    .any_valid (pick_any)
  );

  // Binary index of the picked winner, kept alongside the one-hot grant.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) pick_idx = PTR_W'(i);
    end
  end

  // Read only when the owner still wants data and can take it now.
  always_comb begin
    req_g = |(req & gnt_q);
    rd_en = (state_q == ST_BURST) && req_g
         && ((cons_rdy & gnt_q) != '0)
         && !fifo_empty && (cnt_q < CNT_MAX);
    cnt_d     = cnt_q + CNT_W'(rd_en);
    burst_end = (cnt_d == CNT_MAX) || !req_g;
    ptr_d     = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);
  end

  // Grant FSM; beat-valid lags the read by one cycle via out_valid_q.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      out_valid_q  <= rd_en ? gnt_q : '0;
      burst_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_win;
            gidx_q  <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          cnt_q <= cnt_d;
          if (burst_end) begin
            state_q      <= ST_DRAIN;
            burst_done_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          rr_ptr_q <= ptr_d;
          gnt_q    <= '0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign out_valid  = out_valid_q;
  assign burst_done = burst_done_q;
  assign out_data   = rd_data;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a grant-level reference model.
// FIFO contents live in a queue; expectations come from the model.
module tb_fifo_rd_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [N-1:0]  req;
  logic [N-1:0]  cons_rdy;
  logic          fifo_empty;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic [N-1:0]  gnt;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic          burst_done;

  fifo_rd_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .req        (req),
    .cons_rdy   (cons_rdy),
    .fifo_empty (fifo_empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .gnt        (gnt),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .burst_done (burst_done)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  // FIFO environment
  logic [DW-1:0] fifo_q[$];
  bit            force_empty = 1'b0;
  int            next_val = 8'h10;

  // Reference model: who owns the port, beats taken, grant closing.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_ptr = 0;
  int            m_pend = -1;
  bit            m_closing = 1'b0;
  logic [DW-1:0] m_data = '0;

  // Observations of the DUT
  int gnt_log[$];
  logic [N-1:0] prev_gnt = '0;
  bit prev_rd = 1'b0;
  int n_rd = 0, n_ov = 0, n_bd = 0, n_cut = 0;
  int ov_cnt[N] = '{default: 0};
  bit last_rd, last_bd;
  logic [N-1:0] last_ov;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(next_val));
      next_val++;
    end
    fifo_empty = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic upd_empty();
    fifo_empty = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic tick();
    logic [N-1:0] eg, eov;
    bit erd, ebd;
    int k;
    #1;
    if (rd_rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0;
      m_pend = -1; m_closing = 1'b0;
    end
    eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    erd = (m_owner >= 0) && !m_closing && !rd_rst
       && req[m_owner] && cons_rdy[m_owner]
       && !fifo_empty && (m_beats < BM);
    eov = (m_pend >= 0) ? N'(1 << m_pend) : '0;
    ebd = m_closing;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rd_en", 32'(rd_en), 32'(erd));
    chk("out_valid", 32'(out_valid), 32'(eov));
    chk("burst_done", 32'(burst_done), 32'(ebd));
    if (eov != '0) chk("out_data", 32'(out_data), 32'(m_data));
    // observations
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
    end
    if (rd_rst && prev_rd) n_cut++;
    prev_gnt = gnt;
    prev_rd  = rd_en;
    n_rd += int'(rd_en);
    n_ov += int'(out_valid != '0);
    n_bd += int'(burst_done);
    for (int i = 0; i < N; i++) ov_cnt[i] += int'(out_valid[i]);
    last_rd = rd_en; last_ov = out_valid; last_bd = burst_done;
    @(posedge rd_clk);
    if (!rd_rst) begin
      m_pend = erd ? m_owner : -1;
      if (m_owner < 0) begin
        for (int i = N - 1; i >= 0; i--) begin
          k = (m_ptr + i) % N;
          if (req[k]) m_owner = k;
        end
        m_beats = 0;
        m_closing = 1'b0;
      end else if (m_closing) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_closing = 1'b0;
      end else begin
        if (erd) m_beats++;
        if (m_beats == BM || !req[m_owner]) m_closing = 1'b1;
      end
    end
    #1;
    if (last_rd && !rd_rst && fifo_q.size() > 0) begin
      rd_data = fifo_q.pop_front();
      m_data  = rd_data;
    end
    upd_empty();
    @(negedge rd_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rst_pulse();
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
  endtask

  int s_rd, s_bd, s_ov, s_ov2, gl0;
  logic [6:0] rdv;
  logic [7:0] ovv;
  bit found;

  initial begin
    rd_rst = 1'b1; req = '0; cons_rdy = '1;
    rd_data = '0; fifo_empty = 1'b1;
    @(negedge rd_clk);
    ticks(2);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    rd_rst = 1'b0;

    // S1: single requester, 6 entries -> 4 beats, regrant, 2 beats
    push(6);
    req = 4'b0001;
    s_rd = n_rd; s_bd = n_bd; gl0 = gnt_log.size();
    ticks(16);
    chk("s1_beats", 32'(n_rd - s_rd), 32'd6);
    chk("s1_bdone", 32'(n_bd - s_bd), 32'd1);
    chk("s1_grants", 32'(gnt_log.size() - gl0), 32'd2);
    req = '0;
    ticks(3);

    // S2: all requesting, FIFO never empty -> 0,1,2,3,0 with 4 beats
    push(24);
    rst_pulse();
    req = 4'b1111;
    gl0 = gnt_log.size();
    s_ov = ov_cnt[0]; s_ov2 = n_ov;
    for (int i = 1; i < N; i++) ov_cnt[i] = 0;
    ticks(30);
    req = '0;
    chk("s2_ngrants", 32'(gnt_log.size() - gl0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (gl0 + i < gnt_log.size())
        chk("s2_order", 32'(gnt_log[gl0 + i]), 32'(i % N));
    chk("s2_ov0", 32'(ov_cnt[0] - s_ov), 32'd8);
    for (int i = 1; i < N; i++) chk("s2_ovn", 32'(ov_cnt[i]), 32'd4);
    chk("s2_total", 32'(n_ov - s_ov2), 32'd20);
    ticks(2);

    // S3: requester 2 stalled by empty FIFO for 10 cycles
    rst_pulse();
    force_empty = 1'b1;
    push(8);
    req = 4'b0100;
    s_rd = n_rd;
    ticks(11);
    chk("s3_stall_rd", 32'(n_rd - s_rd), 32'd0);
    force_empty = 1'b0;
    upd_empty();
    s_ov = ov_cnt[2]; s_ov2 = n_ov;
    ticks(6);
    chk("s3_ov2", 32'(ov_cnt[2] - s_ov), 32'd4);
    chk("s3_total", 32'(n_ov - s_ov2), 32'd4);
    req = '0;
    ticks(2);

    // S4: cons_rdy[1] toggling during grant to requester 1
    rst_pulse();
    push(8);
    req = 4'b0010;
    cons_rdy = '1;
    tick();
    rdv = '0; ovv = '0;
    for (int i = 0; i < 8; i++) begin
      cons_rdy[1] = ~i[0];
      tick();
      if (i < 7) rdv[i] = last_rd;
      ovv[i] = last_ov[1];
    end
    chk("s4_rd_pat", 32'(rdv), 32'h55);
    chk("s4_ov_pat", 32'(ovv), 32'hAA);
    cons_rdy = '1;
    req = '0;
    ticks(2);

    // S5: req[3] drops after 2 beats -> DRAIN, pointer wraps to 0
    rst_pulse();
    push(8);
    req = 4'b1000;
    s_rd = n_rd;
    ticks(3);
    chk("s5_beats", 32'(n_rd - s_rd), 32'd2);
    req = '0;
    tick();
    tick();
    chk("s5_bdone", 32'(last_bd), 32'd1);
    req = 4'b1001;
    ticks(2);
    chk("s5_next", 32'(gnt_log[$]), 32'd0);

    // S6: reset right after a read drops the pending beat
    push(16);
    req = 4'b0110;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = last_rd;
    end
    chk("s6_read_seen", 32'(found), 32'd1);
    if (found) begin
      rd_rst = 1'b1;
      tick();
      chk("s6_ov_rst", 32'(last_ov), 32'h0);
      chk("s6_gnt_rst", 32'(gnt), 32'h0);
      rd_rst = 1'b0;
      ticks(2);
      chk("s6_regrant", 32'(gnt_log[$]), 32'd1);
    end
    req = '0;
    ticks(6);
    chk("rd_vs_ov", 32'(n_ov), 32'(n_rd - n_cut));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
